// File: rtl/row_writeback_pkg.sv
// Shared definitions for the row write-back block: default widths,
// the word-width helper and the packing FSM state type.
package row_writeback_pkg;

    localparam int DATA_W_DEF = 24;
    localparam int ADDR_W_DEF = 9;

    // One SRAM word carries an even/odd pair of row sums.
    function automatic int word_width(input int data_w);
        return 2 * data_w;
    endfunction

    typedef enum logic [1:0] {
        S_LO,
        S_HI,
        S_WR,
        S_DONE
    } wb_state_e;

endpackage

// File: rtl/row_writeback_fifo.sv
// wb_fifo: small synchronous FIFO with registered count, full and empty flags.
// The head entry is presented combinationally so it can be popped the cycle after it is pushed.
module wb_fifo #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full  = (count_q == (PTR_W+1)'(DEPTH));
    assign empty = (count_q == '0);
    assign head  = mem[rd_ptr_q];

    // A full FIFO can still take a push when the same cycle pops.
    always_comb begin
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
        rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
        count_d  = count_q + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/row_writeback.sv
// row_writeback: buffers row sums, packs them in pairs and writes them to the result SRAM.
// Optional row-order checking is built when WB_ROWCHK_EN is defined.
module row_writeback
    import row_writeback_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int ROWS       = 512
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          sum_valid,
    input  logic [DATA_W-1:0]             sum_in,
    input  logic [ADDR_W:0]               sum_row,
    output logic                          sum_ready,
    input  logic                          flush,
    output logic                          wr_en,
    output logic [ADDR_W-1:0]             wr_addr,
    output logic [word_width(DATA_W)-1:0] wr_data,
    input  logic                          wr_ready,
    output logic                          done,
    output logic                          seq_err
);

    localparam int WORD_W = word_width(DATA_W);
    localparam int RD_W   = ADDR_W + 2;

    wb_state_e         state_q, state_d;
    logic [DATA_W-1:0] lo_q, lo_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [WORD_W-1:0] wr_data_q, wr_data_d;
    logic [RD_W-1:0]   rows_done_q, rows_done_d;
    logic              flushed_q, flushed_d;

    logic              push_acc;
    logic              fifo_pop;
    logic [DATA_W-1:0] fifo_head;
    logic              fifo_full;
    logic              fifo_empty;

    assign sum_ready = !fifo_full && (state_q != S_DONE);
    assign push_acc  = sum_valid && sum_ready;
    assign wr_en     = wr_en_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign done      = (state_q == S_DONE);

    wb_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (push_acc),
        .push_data (sum_in),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_comb begin
        state_d     = state_q;
        lo_d        = lo_q;
        wr_en_d     = wr_en_q;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        rows_done_d = rows_done_q;
        flushed_d   = flushed_q;
        fifo_pop    = 1'b0;

        case (state_q)
            S_LO: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    lo_d     = fifo_head;
                    state_d  = S_HI;
                end
            end
            S_HI: begin
                if (!fifo_empty) begin
                    fifo_pop  = 1'b1;
                    wr_data_d = {fifo_head, lo_q};
                    wr_en_d   = 1'b1;
                    flushed_d = 1'b0;
                    state_d   = S_WR;
                end else if (flush) begin
                    wr_data_d = {{DATA_W{1'b0}}, lo_q};
                    wr_en_d   = 1'b1;
                    flushed_d = 1'b1;
                    state_d   = S_WR;
                end
            end
            S_WR: begin
                // A flushed word carries only one real row.
                if (wr_ready) begin
                    wr_en_d     = 1'b0;
                    wr_addr_d   = wr_addr_q + ADDR_W'(1);
                    rows_done_d = rows_done_q + (flushed_q ? RD_W'(1) : RD_W'(2));
                    state_d     = (rows_done_d >= RD_W'(ROWS)) ? S_DONE : S_LO;
                end
            end
            S_DONE: begin
                state_d = S_DONE;
            end
            default: begin
                state_d = S_LO;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= S_LO;
            lo_q        <= '0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            rows_done_q <= '0;
            flushed_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            lo_q        <= lo_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            rows_done_q <= rows_done_d;
            flushed_q   <= flushed_d;
        end
    end

`ifdef WB_ROWCHK_EN
    logic [ADDR_W:0] exp_row_q, exp_row_d;
    logic            seq_err_q, seq_err_d;

    // Out-of-order rows are flagged but still stored; the check never stalls.
    always_comb begin
        exp_row_d = exp_row_q;
        seq_err_d = seq_err_q;
        if (push_acc) begin
            exp_row_d = exp_row_q + (ADDR_W+1)'(1);
            if (sum_row != exp_row_q) begin
                seq_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            exp_row_q <= '0;
            seq_err_q <= 1'b0;
        end else begin
            exp_row_q <= exp_row_d;
            seq_err_q <= seq_err_d;
        end
    end

    assign seq_err = seq_err_q;
`else
    logic unused_sum_row;

    assign unused_sum_row = ^sum_row;
    assign seq_err        = 1'b0;
`endif

endmodule

// File: tb/tb_row_writeback.sv
// Self-checking bench for row_writeback: directed scenarios plus randomized traffic
// checked against a queue-based model of pair packing and sequential addressing.
`timescale 1ns/1ps
module tb_row_writeback;

    localparam int DATA_W = 24;
    localparam int ADDR_W = 9;
    localparam int ROWS   = 8;

    logic                  clock;
    logic                  reset;
    logic                  sum_valid;
    logic [DATA_W-1:0]     sum_in;
    logic [ADDR_W:0]       sum_row;
    logic                  sum_ready;
    logic                  flush;
    logic                  wr_en;
    logic [ADDR_W-1:0]     wr_addr;
    logic [2*DATA_W-1:0]   wr_data;
    logic                  wr_ready;
    logic                  done;
    logic                  seq_err;

    int checks;
    int failures;

    // Reference model state: sums accepted but not yet paired, and words owed to the SRAM.
    logic [DATA_W-1:0]   pend[$];
    logic [2*DATA_W-1:0] exp_words[$];
    int                  exp_addr;
    int                  writes;
    int                  pushes;
    int                  wr_en_cycles;
    logic                last_acc;
    logic                hold_valid;
    logic [2*DATA_W-1:0] hold_data;
    logic [ADDR_W-1:0]   hold_addr;

    row_writeback #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (4),
        .ADDR_W     (ADDR_W),
        .ROWS       (ROWS)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .sum_valid (sum_valid),
        .sum_in    (sum_in),
        .sum_row   (sum_row),
        .sum_ready (sum_ready),
        .flush     (flush),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_ready  (wr_ready),
        .done      (done),
        .seq_err   (seq_err)
    );

    // Free-running 10 ns clock.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Hard stop in case something wedges beyond every bounded wait.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog expired got=running expected=finished");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // One clock: sample at the falling edge, update the model, then step past the rising edge.
    task automatic tick();
        @(negedge clock);
        last_acc = sum_valid && sum_ready;
        if (last_acc) begin
            pend.push_back(sum_in);
            pushes++;
            if (pend.size() == 2) begin
                exp_words.push_back({pend[1], pend[0]});
                pend.delete();
            end
        end
        if (wr_en) begin
            wr_en_cycles++;
            if (hold_valid) begin
                checkOutput("hold_data", wr_data, hold_data);
                checkOutput("hold_addr", wr_addr, hold_addr);
            end
            if (wr_ready) begin
                checkOutput("write_expected", exp_words.size() > 0, 1);
                if (exp_words.size() > 0) begin
                    checkOutput("wr_data", wr_data, exp_words.pop_front());
                    checkOutput("wr_addr", wr_addr, exp_addr);
                end
                exp_addr   = (exp_addr + 1) % (1 << ADDR_W);
                writes++;
                hold_valid = 1'b0;
            end else begin
                hold_valid = 1'b1;
                hold_data  = wr_data;
                hold_addr  = wr_addr;
            end
        end else begin
            hold_valid = 1'b0;
        end
        @(posedge clock);
        #1;
    endtask

    task automatic clearModel();
        pend.delete();
        exp_words.delete();
        exp_addr     = 0;
        writes       = 0;
        pushes       = 0;
        wr_en_cycles = 0;
        hold_valid   = 1'b0;
        last_acc     = 1'b0;
    endtask

    task automatic doReset();
        reset     = 1'b0;
        sum_valid = 1'b0;
        flush     = 1'b0;
        wr_ready  = 1'b0;
        sum_in    = '0;
        sum_row   = '0;
        clearModel();
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
    endtask

    // Offer one sum until it is accepted (bounded).
    task automatic applyStimulus(input logic [DATA_W-1:0] data, input logic [ADDR_W:0] row);
        sum_valid = 1'b1;
        sum_in    = data;
        sum_row   = row;
        last_acc  = 1'b0;
        for (int i = 0; i < 50 && !last_acc; i++) begin
            tick();
        end
        sum_valid = 1'b0;
        checkOutput("push_accepted", last_acc, 1);
    endtask

    task automatic waitWrites(input int target, input int budget);
        for (int i = 0; i < budget && writes < target; i++) begin
            tick();
        end
        checkOutput("write_count", writes, target);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
        end
    endtask

    initial begin
        int k;
        int accepted;
        int exp_seq;
        logic [DATA_W-1:0] data_tab[8];

        checks   = 0;
        failures = 0;
        clearModel();

        // Reset values while reset is held.
        reset     = 1'b0;
        sum_valid = 1'b0;
        flush     = 1'b0;
        wr_ready  = 1'b0;
        sum_in    = '0;
        sum_row   = '0;
        #3;
        checkOutput("reset_wr_en", wr_en, 0);
        checkOutput("reset_wr_addr", wr_addr, 0);
        checkOutput("reset_wr_data", wr_data, 0);
        checkOutput("reset_done", done, 0);
        checkOutput("reset_seq_err", seq_err, 0);
        doReset();
        @(negedge clock);
        checkOutput("ready_after_reset", sum_ready, 1);
        @(posedge clock);
        #1;

        // Basic pair.
        $display("[TB] basic pair");
        wr_ready = 1'b1;
        applyStimulus(24'h000011, 0);
        applyStimulus(24'h000022, 1);
        waitWrites(1, 20);
        idle(3);
        checkOutput("basic_wr_en_cycles", wr_en_cycles, 1);
        checkOutput("basic_done", done, 0);

        // Backpressure: 2 sums in the pending word plus 4 in the FIFO.
        $display("[TB] backpressure");
        doReset();
        for (int i = 0; i < 8; i++) data_tab[i] = DATA_W'($urandom);
        k         = 0;
        sum_valid = 1'b1;
        for (int i = 0; i < 14; i++) begin
            sum_in  = data_tab[k];
            sum_row = (ADDR_W+1)'(k);
            tick();
            if (last_acc) k++;
        end
        sum_valid = 1'b0;
        accepted  = k;
        checkOutput("bp_accepted", accepted, 6);
        checkOutput("bp_sum_ready", sum_ready, 0);
        checkOutput("bp_wr_en_held", wr_en, 1);
        wr_ready = 1'b1;
        waitWrites(3, 40);

        // Flush of a half-filled word.
        $display("[TB] flush");
        doReset();
        wr_ready = 1'b1;
        applyStimulus(24'hFFFFFF, 0);
        exp_words.push_back({24'h000000, pend[0]});
        pend.delete();
        flush = 1'b1;
        idle(2);
        flush = 1'b0;
        waitWrites(1, 20);
        checkOutput("flush_done", done, 0);

        // Completion after ROWS sums.
        $display("[TB] completion");
        doReset();
        wr_ready = 1'b1;
        for (int i = 0; i < ROWS; i++) begin
            applyStimulus(DATA_W'($urandom), (ADDR_W+1)'(i));
        end
        waitWrites(ROWS / 2, 100);
        idle(1);
        checkOutput("done_set", done, 1);
        checkOutput("done_sum_ready", sum_ready, 0);
        sum_valid = 1'b1;
        sum_in    = 24'h123456;
        idle(6);
        sum_valid = 1'b0;
        checkOutput("done_no_push", pushes, ROWS);
        checkOutput("done_no_write", writes, ROWS / 2);
        checkOutput("done_sticky", done, 1);

        // Reset while a write is pending.
        $display("[TB] reset mid-write");
        doReset();
        wr_ready = 1'b1;
        applyStimulus(24'h0000A1, 0);
        applyStimulus(24'h0000B2, 1);
        waitWrites(1, 20);
        wr_ready = 1'b0;
        applyStimulus(24'h0000C3, 2);
        applyStimulus(24'h0000D4, 3);
        for (int i = 0; i < 20 && !wr_en; i++) tick();
        checkOutput("midwr_wr_en", wr_en, 1);
        checkOutput("midwr_wr_addr", wr_addr, 1);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("async_wr_en", wr_en, 0);
        checkOutput("async_wr_addr", wr_addr, 0);
        doReset();
        wr_ready = 1'b1;
        applyStimulus(24'h0000E5, 0);
        applyStimulus(24'h0000F6, 1);
        waitWrites(1, 20);

        // Row order check.
        $display("[TB] row order");
        doReset();
        wr_ready = 1'b1;
        applyStimulus(24'h000101, 0);
        applyStimulus(24'h000202, 1);
        idle(1);
        checkOutput("seq_ok", seq_err, 0);
        applyStimulus(24'h000303, 3);
        idle(1);
`ifdef WB_ROWCHK_EN
        exp_seq = 1;
`else
        exp_seq = 0;
`endif
        checkOutput("seq_err", seq_err, 1'(exp_seq));
        waitWrites(1, 20);
        checkOutput("seq_pending", pend.size(), 1);

        // Randomized traffic with random valid and backpressure.
        $display("[TB] random");
        for (int r = 0; r < 4; r++) begin
            doReset();
            k = 0;
            for (int i = 0; i < 600 && !(writes >= ROWS / 2 && k >= ROWS); i++) begin
                sum_valid = (k < ROWS) && ($urandom_range(0, 1) == 1);
                sum_in    = DATA_W'($urandom);
                sum_row   = (ADDR_W+1)'(k);
                wr_ready  = ($urandom_range(0, 9) < 7);
                tick();
                if (last_acc) k++;
                if (writes < ROWS / 2 && !done) begin
                    checkOutput("rand_not_done", done, 0);
                end
            end
            sum_valid = 1'b0;
            idle(1);
            checkOutput("rand_writes", writes, ROWS / 2);
            checkOutput("rand_done", done, 1);
            checkOutput("rand_seq_err", seq_err, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/row_writeback.md
Name: row_writeback

Overview:
- Sits directly downstream of the row-accumulation adder tree.
- Accepts each completed 24-bit row sum and buffers it in a small FIFO.
- Packs row sums in pairs into 48-bit words and writes them sequentially into the result SRAM through a valid/ready write port.
- Raises done once every row of the matrix has been committed.

Parameters:
- DATA_W, 24, width of one row sum.
- FIFO_DEPTH, 4, input buffer entries; power of two, ≥2.
- ADDR_W, 9, result SRAM word-address width.
- ROWS, 512, rows per matrix; must be even; ROWS/2 words are written.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- sum_valid  in  1  row sum present on sum_in.
- sum_in  in  DATA_W  completed row sum (two's complement).
- sum_row  in  ADDR_W+1  row index of sum_in.
- sum_ready  out  1  block can accept a sum this cycle.
- flush  in  1  force out a pending half-filled word.
- wr_en  out  1  write request to result SRAM.
- wr_addr  out  ADDR_W  word address.
- wr_data  out  2*DATA_W  {odd row sum, even row sum}.
- wr_ready  in  1  SRAM accepts the write this cycle.
- done  out  1  all ROWS sums committed; sticky.
- seq_err  out  1  sticky row-order error (optional feature).

Behaviour:
- Reset (reset=0, asynchronous): clears FIFO pointers and count, FSM to S_LO, and zeroes wr_en, wr_addr, wr_data, done and seq_err. FIFO contents are discarded. sum_ready=1 on the first cycle after release.
- Push: sum_ready = !full && state!=S_DONE. A sum is accepted when sum_valid && sum_ready at the clock edge.
  - Push and pop in the same cycle are legal at any count, including full-with-pop. sum_ready, however, is computed from the registered count only, with no pop lookahead.
- Pop: occurs only in S_LO or S_HI with FIFO non-empty, at most one entry per cycle. Minimum latency from push edge to pop edge is 1 cycle.
- FSM:
  - S_LO: on pop, lo_reg<=head and go to S_HI.
  - S_HI, on pop: wr_data<={head,lo_reg}, wr_en<=1, go to S_WR.
  - S_HI, when flush && FIFO empty: wr_data<={0,lo_reg}, wr_en<=1, go to S_WR. flush has no effect in other states.
  - S_WR: hold wr_en, wr_addr and wr_data stable until wr_ready.
    - On wr_ready: wr_en<=0, wr_addr<=wr_addr+1, rows_done<=rows_done+2 (+1 for a flushed word), go to S_LO.
    - If the updated rows_done ≥ ROWS, go to S_DONE instead.
  - S_DONE: done=1, sum_ready=0, no further writes. Exit only by reset.
- Write timing: wr_en rises the cycle after the second (odd) half is popped. With wr_ready held high, the steady state is one word per 3 cycles. The FIFO absorbs bursts from the adder tree.
- wr_addr wraps modulo 2^ADDR_W. This is unreachable for ROWS ≤ 2^(ADDR_W+1).
- No arithmetic is performed on sums; bits pass through unchanged.

Optional Feature:
- Macro: WB_ROWCHK_EN.
- Defined:
  - An expected-row counter increments on each accepted push.
  - If sum_row != expected on an accepted push, seq_err is set sticky.
  - The data is still stored; the check never stalls.
- Undefined: seq_err is tied 0, sum_row is ignored, and the counter is not built.

Decomposition:
- Shared package holds:
  - DATA_W and ADDR_W defaults, and the word width 2*DATA_W.
  - The state enum {S_LO, S_HI, S_WR, S_DONE}.
- One sub-module is natural: wb_fifo, a synchronous FIFO with count, full and empty, parameterised on width and depth. The FSM, packing and counters stay in row_writeback.

Test Plan:
- Basic pair: push 0x000011 (row 0) then 0x000022 (row 1), wr_ready=1. Expect one write, wr_addr=0, wr_data=0x000022_000011, and wr_en high exactly 1 cycle.
- Backpressure: hold wr_ready=0 and push 6 sums. Expect sum_ready to fall after 4 + 2 are absorbed. wr_data and wr_addr stay stable. Releasing wr_ready yields 3 writes at addresses 0, 1, 2 in order.
- Flush: push a single sum 0xFFFFFF, then pulse flush. Expect wr_data=0x000000_FFFFFF and wr_addr=0.
- Completion: with ROWS=4, push 4 sums. Expect 2 writes, then done=1 and sum_ready=0. A further sum_valid is ignored and produces no write.
- Reset mid-write: assert reset while in S_WR with wr_en=1. Expect wr_en=0 and wr_addr=0 immediately (asynchronously). After release, the next pair writes to address 0.
- With WB_ROWCHK_EN defined: push rows 0, 1, 3. Expect seq_err=1 after the third push; data is still written. Without the macro, seq_err stays 0.
